// File: rtl/simple_alu_arbiter.sv
// Two-lane round-robin front end for one shared combinational ALU.
// Each lane has a one-entry operand buffer; the ALU output is captured in a single writeback register.
module simple_alu_arbiter #(
  parameter int SIZE_DATA       = 32,
  parameter int SIZE_IMMEDIATE  = 16,
  parameter int SIZE_OPCODE_I   = 8,
  parameter int EXECUTION_FLAGS = 6,
  parameter int SIZE_TAG        = 7
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush_i,
  input  logic                       req0_valid_i,
  output logic                       req0_ready_o,
  input  logic [SIZE_DATA-1:0]       req0_data1_i,
  input  logic [SIZE_DATA-1:0]       req0_data2_i,
  input  logic [SIZE_IMMEDIATE-1:0]  req0_immd_i,
  input  logic [SIZE_OPCODE_I-1:0]   req0_opcode_i,
  input  logic [SIZE_TAG-1:0]        req0_tag_i,
  input  logic                       req1_valid_i,
  output logic                       req1_ready_o,
  input  logic [SIZE_DATA-1:0]       req1_data1_i,
  input  logic [SIZE_DATA-1:0]       req1_data2_i,
  input  logic [SIZE_IMMEDIATE-1:0]  req1_immd_i,
  input  logic [SIZE_OPCODE_I-1:0]   req1_opcode_i,
  input  logic [SIZE_TAG-1:0]        req1_tag_i,
  output logic [SIZE_DATA-1:0]       alu_data1_o,
  output logic [SIZE_DATA-1:0]       alu_data2_o,
  output logic [SIZE_IMMEDIATE-1:0]  alu_immd_o,
  output logic [SIZE_OPCODE_I-1:0]   alu_opcode_o,
  input  logic [SIZE_DATA-1:0]       alu_result_i,
  input  logic [EXECUTION_FLAGS-1:0] alu_flags_i,
  output logic                       wb_valid_o,
  input  logic                       wb_ready_i,
  output logic [SIZE_DATA-1:0]       wb_result_o,
  output logic [EXECUTION_FLAGS-1:0] wb_flags_o,
  output logic [SIZE_TAG-1:0]        wb_tag_o,
  output logic                       wb_src_o,
  output logic [15:0]                stall_cnt_o
);

  typedef struct packed {
    logic [SIZE_DATA-1:0]      data1;
    logic [SIZE_DATA-1:0]      data2;
    logic [SIZE_IMMEDIATE-1:0] immd;
    logic [SIZE_OPCODE_I-1:0]  opcode;
    logic [SIZE_TAG-1:0]       tag;
  } entry_t;

  entry_t [1:0]               buf_q, buf_d;
  logic   [1:0]               buf_valid_q, buf_valid_d;
  logic                       last_grant_q, last_grant_d;
  logic                       wb_valid_q, wb_valid_d;
  logic [SIZE_DATA-1:0]       wb_result_q, wb_result_d;
  logic [EXECUTION_FLAGS-1:0] wb_flags_q, wb_flags_d;
  logic [SIZE_TAG-1:0]        wb_tag_q, wb_tag_d;
  logic                       wb_src_q, wb_src_d;
  logic [15:0]                stall_q, stall_d;

  entry_t [1:0] req_in;
  entry_t       sel;
  logic [1:0]   req_valid, ready;
  logic         issue, grant;

  always_comb begin
    req_in[0] = '{data1: req0_data1_i, data2: req0_data2_i, immd: req0_immd_i,
                  opcode: req0_opcode_i, tag: req0_tag_i};
    req_in[1] = '{data1: req1_data1_i, data2: req1_data2_i, immd: req1_immd_i,
                  opcode: req1_opcode_i, tag: req1_tag_i};
    req_valid = {req1_valid_i, req0_valid_i};

    issue = (|buf_valid_q) & (~wb_valid_q | wb_ready_i);
    // Lane 1 only wins alone or on its round-robin turn; idle state points at buf0.
    if (&buf_valid_q) grant = ~last_grant_q;
    else              grant = buf_valid_q[1];
    sel = buf_q[grant];

    buf_d       = buf_q;
    buf_valid_d = buf_valid_q;
    for (int unsigned i = 0; i < 2; i++) begin
      ready[i] = ~buf_valid_q[i] | ((grant == 1'(i)) & issue);
      if (issue && grant == 1'(i)) buf_valid_d[i] = 1'b0;
      if (req_valid[i] && ready[i]) begin
        buf_d[i]       = req_in[i];
        buf_valid_d[i] = 1'b1;
      end
      if (flush_i) buf_valid_d[i] = 1'b0;
    end

    wb_valid_d   = wb_valid_q;
    wb_result_d  = wb_result_q;
    wb_flags_d   = wb_flags_q;
    wb_tag_d     = wb_tag_q;
    wb_src_d     = wb_src_q;
    last_grant_d = issue ? grant : last_grant_q;
    if (flush_i) begin
      wb_valid_d = 1'b0;
    end else if (issue) begin
      wb_valid_d  = 1'b1;
      wb_result_d = alu_result_i;
      wb_flags_d  = alu_flags_i;
      wb_tag_d    = sel.tag;
      wb_src_d    = grant;
    end else if (wb_ready_i && wb_valid_q) begin
      wb_valid_d = 1'b0;
    end

    stall_d = stall_q;
    if (wb_valid_q && !wb_ready_i && stall_q != '1) stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_q        <= '0;
      buf_valid_q  <= '0;
      last_grant_q <= 1'b1;
      wb_valid_q   <= 1'b0;
      wb_result_q  <= '0;
      wb_flags_q   <= '0;
      wb_tag_q     <= '0;
      wb_src_q     <= 1'b0;
      stall_q      <= '0;
    end else begin
      buf_q        <= buf_d;
      buf_valid_q  <= buf_valid_d;
      last_grant_q <= last_grant_d;
      wb_valid_q   <= wb_valid_d;
      wb_result_q  <= wb_result_d;
      wb_flags_q   <= wb_flags_d;
      wb_tag_q     <= wb_tag_d;
      wb_src_q     <= wb_src_d;
      stall_q      <= stall_d;
    end
  end

  assign req0_ready_o = ready[0];
  assign req1_ready_o = ready[1];
  assign alu_data1_o  = sel.data1;
  assign alu_data2_o  = sel.data2;
  assign alu_immd_o   = sel.immd;
  assign alu_opcode_o = sel.opcode;
  assign wb_valid_o   = wb_valid_q;
  assign wb_result_o  = wb_result_q;
  assign wb_flags_o   = wb_flags_q;
  assign wb_tag_o     = wb_tag_q;
  assign wb_src_o     = wb_src_q;
  assign stall_cnt_o  = stall_q;

endmodule

// File: tb/tb_simple_alu_arbiter.sv
// Directed bench for simple_alu_arbiter: handshake latency, round-robin order,
// back-pressure, flush, stall saturation and asynchronous reset.
module tb_simple_alu_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush_i = 1'b0;
  logic        req0_valid_i = 1'b0, req1_valid_i = 1'b0;
  logic        req0_ready_o, req1_ready_o;
  logic [31:0] req0_data1_i = '0, req0_data2_i = '0, req1_data1_i = '0, req1_data2_i = '0;
  logic [15:0] req0_immd_i = '0, req1_immd_i = '0;
  logic [7:0]  req0_opcode_i = '0, req1_opcode_i = '0;
  logic [6:0]  req0_tag_i = '0, req1_tag_i = '0;
  logic [31:0] alu_data1_o, alu_data2_o, alu_result_i;
  logic [15:0] alu_immd_o;
  logic [7:0]  alu_opcode_o;
  logic [5:0]  alu_flags_i;
  logic        wb_valid_o, wb_src_o;
  logic        wb_ready_i = 1'b1;
  logic [31:0] wb_result_o;
  logic [5:0]  wb_flags_o;
  logic [6:0]  wb_tag_o;
  logic [15:0] stall_cnt_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Stand-in ALU: result is the operand sum, flags echo the low opcode bits.
  always_comb begin
    alu_result_i = alu_data1_o + alu_data2_o;
    alu_flags_i  = alu_opcode_o[5:0];
  end

  simple_alu_arbiter #(
    .SIZE_DATA(32), .SIZE_IMMEDIATE(16), .SIZE_OPCODE_I(8),
    .EXECUTION_FLAGS(6), .SIZE_TAG(7)
  ) dut (
    .clk(clk), .reset(reset), .flush_i(flush_i),
    .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o),
    .req0_data1_i(req0_data1_i), .req0_data2_i(req0_data2_i),
    .req0_immd_i(req0_immd_i), .req0_opcode_i(req0_opcode_i), .req0_tag_i(req0_tag_i),
    .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o),
    .req1_data1_i(req1_data1_i), .req1_data2_i(req1_data2_i),
    .req1_immd_i(req1_immd_i), .req1_opcode_i(req1_opcode_i), .req1_tag_i(req1_tag_i),
    .alu_data1_o(alu_data1_o), .alu_data2_o(alu_data2_o), .alu_immd_o(alu_immd_o),
    .alu_opcode_o(alu_opcode_o), .alu_result_i(alu_result_i), .alu_flags_i(alu_flags_i),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i), .wb_result_o(wb_result_o),
    .wb_flags_o(wb_flags_o), .wb_tag_o(wb_tag_o), .wb_src_o(wb_src_o),
    .stall_cnt_o(stall_cnt_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  int n0, n1, k;
  bit started;

  task automatic drive_lanes();
    req0_valid_i  = (n0 < 8);
    req0_data1_i  = 32'h10 + 32'(n0);
    req0_data2_i  = 32'h100;
    req0_immd_i   = 16'h10 + 16'(n0);
    req0_opcode_i = 8'h01;
    req0_tag_i    = 7'h10 + 7'(n0);
    req1_valid_i  = (n1 < 8);
    req1_data1_i  = 32'h20 + 32'(n1);
    req1_data2_i  = 32'h200;
    req1_immd_i   = 16'h20 + 16'(n1);
    req1_opcode_i = 8'h02;
    req1_tag_i    = 7'h20 + 7'(n1);
  endtask

  initial begin
    logic [31:0] exp_tag;

    // Reset values and single ADD on lane 0
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check_eq("rst_wb_valid", 32'(wb_valid_o), 32'd0);
    check_eq("rst_wb_result", wb_result_o, 32'd0);
    check_eq("rst_wb_tag", 32'(wb_tag_o), 32'd0);
    check_eq("rst_wb_src", 32'(wb_src_o), 32'd0);
    check_eq("rst_stall", 32'(stall_cnt_o), 32'd0);
    check_eq("rst_ready0", 32'(req0_ready_o), 32'd1);
    check_eq("rst_ready1", 32'(req1_ready_o), 32'd1);
    req0_valid_i = 1'b1; req0_data1_i = 32'd5; req0_data2_i = 32'd7;
    req0_immd_i = 16'h0abc; req0_opcode_i = 8'h05; req0_tag_i = 7'd3;
    @(negedge clk);
    req0_valid_i = 1'b0;
    check_eq("add_alu_data1", alu_data1_o, 32'd5);
    check_eq("add_alu_immd", 32'(alu_immd_o), 32'h0abc);
    check_eq("add_wb_early", 32'(wb_valid_o), 32'd0);
    @(negedge clk);
    check_eq("add_wb_valid", 32'(wb_valid_o), 32'd1);
    check_eq("add_wb_result", wb_result_o, 32'd12);
    check_eq("add_wb_tag", 32'(wb_tag_o), 32'd3);
    check_eq("add_wb_src", 32'(wb_src_o), 32'd0);
    check_eq("add_wb_flags", 32'(wb_flags_o), 32'd5);
    @(negedge clk);
    check_eq("add_wb_drained", 32'(wb_valid_o), 32'd0);

    // Conflict with a 10-cycle back-pressure window, after a fresh reset
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n0 = 0; n1 = 0; k = 0; started = 0;
    drive_lanes();
    for (int cyc = 0; cyc < 100 && k < 16; cyc++) begin
      @(negedge clk);
      if (cyc == 8) wb_ready_i = 1'b0;
      if (cyc == 17) begin
        check_eq("bp_ready0", 32'(req0_ready_o), 32'd0);
        check_eq("bp_ready1", 32'(req1_ready_o), 32'd0);
      end
      if (cyc == 18) begin
        check_eq("bp_stall_cnt", 32'(stall_cnt_o), 32'd10);
        wb_ready_i = 1'b1;
      end
      if (wb_valid_o) begin
        started = 1;
        exp_tag = (k % 2 == 0) ? 32'h10 + 32'(k / 2) : 32'h20 + 32'(k / 2);
        check_eq("rr_tag", 32'(wb_tag_o), exp_tag);
        check_eq("rr_src", 32'(wb_src_o), 32'(k % 2));
        check_eq("rr_result", wb_result_o, exp_tag + ((k % 2 == 0) ? 32'h100 : 32'h200));
        check_eq("rr_flags", 32'(wb_flags_o), (k % 2 == 0) ? 32'd1 : 32'd2);
        if (wb_ready_i) k++;
      end else if (started) begin
        check_eq("rr_bubble", 32'(wb_valid_o), 32'd1);
      end
      if (req0_valid_i && req0_ready_o) n0++;
      if (req1_valid_i && req1_ready_o) n1++;
      drive_lanes();
    end
    check_eq("rr_count", 32'(k), 32'd16);

    // Flush with both buffers and the output register full
    @(negedge clk);
    wb_ready_i = 1'b0;
    req0_valid_i = 1'b1; req0_tag_i = 7'h30;
    req1_valid_i = 1'b1; req1_tag_i = 7'h40;
    @(negedge clk);
    req0_tag_i = 7'h31;
    req1_valid_i = 1'b0;
    @(negedge clk);
    req0_valid_i = 1'b0;
    check_eq("fl_wb_full", 32'(wb_valid_o), 32'd1);
    check_eq("fl_pre_ready0", 32'(req0_ready_o), 32'd0);
    check_eq("fl_pre_ready1", 32'(req1_ready_o), 32'd0);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    check_eq("fl_wb_valid", 32'(wb_valid_o), 32'd0);
    check_eq("fl_ready0", 32'(req0_ready_o), 32'd1);
    check_eq("fl_ready1", 32'(req1_ready_o), 32'd1);
    wb_ready_i = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_eq("fl_no_wb", 32'(wb_valid_o), 32'd0);
    end

    // Flush and accept in the same cycle
    req0_valid_i = 1'b1; req0_tag_i = 7'h35;
    flush_i = 1'b1;
    @(negedge clk);
    req0_valid_i = 1'b0; flush_i = 1'b0;
    check_eq("fa_ready0", 32'(req0_ready_o), 32'd1);
    @(negedge clk);
    check_eq("fa_no_wb", 32'(wb_valid_o), 32'd0);

    // Stall counter saturation
    wb_ready_i = 1'b0;
    req0_valid_i = 1'b1; req0_data1_i = 32'd1; req0_data2_i = 32'd2; req0_tag_i = 7'h44;
    @(negedge clk);
    req0_valid_i = 1'b0;
    repeat (70000) @(negedge clk);
    check_eq("sat_stall", 32'(stall_cnt_o), 32'hffff);
    check_eq("sat_wb_tag", 32'(wb_tag_o), 32'h44);
    check_eq("sat_wb_valid", 32'(wb_valid_o), 32'd1);

    // Asynchronous reset between edges, then first conflict goes to lane 0
    #2 reset = 1'b1;
    #1;
    check_eq("ar_wb_valid", 32'(wb_valid_o), 32'd0);
    check_eq("ar_stall", 32'(stall_cnt_o), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    wb_ready_i = 1'b1;
    req0_valid_i = 1'b1; req0_tag_i = 7'h50;
    req1_valid_i = 1'b1; req1_tag_i = 7'h60;
    @(negedge clk);
    req0_valid_i = 1'b0; req1_valid_i = 1'b0;
    @(negedge clk);
    check_eq("ar_first_src", 32'(wb_src_o), 32'd0);
    check_eq("ar_first_tag", 32'(wb_tag_o), 32'h50);
    @(negedge clk);
    check_eq("ar_second_src", 32'(wb_src_o), 32'd1);
    check_eq("ar_second_tag", 32'(wb_tag_o), 32'h60);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/simple_alu_arbiter.md
# simple_alu_arbiter

Shares one combinational Simple ALU between two issue lanes in the EXECUTE stage. Each lane has a one-entry operand buffer behind a valid/ready handshake. A round-robin arbiter drives the selected buffer's operands onto the ALU. The ALU result, flags and destination tag are captured in a single output register toward writeback, with stall accounting and a flush path.

## Interface
Parameters:
- SIZE_DATA, 32: operand/result width.
- SIZE_IMMEDIATE, 16: immediate width.
- SIZE_OPCODE_I, 8: opcode width.
- EXECUTION_FLAGS, 6: ALU flag width.
- SIZE_TAG, 7: destination physical-register tag width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- flush_i  in  1  synchronous flush of all in-flight work.
- reqN_valid_i (N=0,1)  in  1  lane N offers an instruction.
- reqN_ready_o  out  1  lane N buffer can accept this cycle.
- reqN_data1_i / reqN_data2_i  in  SIZE_DATA  operands.
- reqN_immd_i  in  SIZE_IMMEDIATE  immediate.
- reqN_opcode_i  in  SIZE_OPCODE_I  opcode.
- reqN_tag_i  in  SIZE_TAG  destination tag.
- alu_data1_o / alu_data2_o  out  SIZE_DATA  operands to the ALU.
- alu_immd_o  out  SIZE_IMMEDIATE  immediate to the ALU.
- alu_opcode_o  out  SIZE_OPCODE_I  opcode to the ALU.
- alu_result_i  in  SIZE_DATA  combinational ALU result.
- alu_flags_i  in  EXECUTION_FLAGS  combinational ALU flags.
- wb_valid_o  out  1  output register holds a result.
- wb_ready_i  in  1  writeback consumes the result.
- wb_result_o  out  SIZE_DATA  registered result.
- wb_flags_o  out  EXECUTION_FLAGS  registered flags.
- wb_tag_o  out  SIZE_TAG  registered tag.
- wb_src_o  out  1  lane that produced the result.
- stall_cnt_o  out  16  saturating count of writeback back-pressure cycles.

## Operation
Buffers:
- bufN holds valid, data1, data2, immd, opcode and tag.
- Accept on lane N when reqN_valid_i & reqN_ready_o.
- reqN_ready_o = ~bufN_valid | (grantN & issue).

Arbitration:
- issue = (buf0_valid | buf1_valid) & (~wb_valid_o | wb_ready_i).
- With one buffer valid, that buffer is granted.
- With both valid, the lane other than last_grant is granted.
- last_grant updates to the granted lane only on issue.

ALU drive and capture:
- The ALU ports always reflect the granted buffer.
- When no buffer is valid, the ALU is driven with buf0 contents; these are don't-care.
- On issue, the output register loads alu_result_i, alu_flags_i, the buffer tag and the lane index, and wb_valid_o goes to 1.
- On issue, the granted buffer clears, unless it is refilled the same edge.
- When wb_ready_i & wb_valid_o & ~issue, wb_valid_o goes to 0.
- Opcodes are not interpreted; NOP is issued like any other opcode.

Flush:
- flush_i clears buf0_valid, buf1_valid and wb_valid_o at the edge.
- Accepts and issues in a flush cycle are discarded.
- reqN_ready_o remains as computed during a flush cycle.
- last_grant and stall_cnt_o are unaffected by flush.

Stall counter:
- Increments when wb_valid_o & ~wb_ready_i.
- Saturates at 16'hFFFF.

## Timing
Reset values:
- All buffer valids = 0.
- wb_valid_o = 0; wb_result_o, wb_flags_o, wb_tag_o, wb_src_o = 0.
- last_grant = 1, so lane 0 wins the first conflict.
- stall_cnt_o = 0.

Latency:
- Accept at edge E, issue at edge E+1 if the output register is free.
- The result is visible on wb_* in the cycle following E+1.

Throughput:
- One result per cycle total.
- One result per cycle per lane when the other lane is idle (buffer refills on its issue edge).

Boundary conditions:
- Output register full and wb_ready_i = 0: issue = 0, buffers hold, and readys drop once a buffer is full.
- Output register full and wb_ready_i = 1: drain and reload occur at the same edge; no bubble.
- Flush and accept in the same cycle: flush wins, and the buffer stays empty.
- Reset asserted mid-operation clears state immediately, independent of clk.

## Test plan
- Single ADD: lane 0, data1=5, data2=7, tag=3 at cycle 0, wb_ready_i=1 -> wb_valid_o=1 in cycle 2 with wb_result_o=12, wb_tag_o=3, wb_src_o=0.
- Conflict: both lanes valid every cycle after reset, tags 0x10.. on lane 0 and 0x20.. on lane 1 -> wb_src_o sequence 0,1,0,1…, no lost or duplicated tags, one result per cycle.
- Back-pressure: wb_ready_i=0 for 10 cycles with both lanes full -> both readys 0, wb_* stable, stall_cnt_o=10; on release, the pending results drain in consecutive cycles.
- Saturation: hold wb_ready_i=0 for 70000 cycles -> stall_cnt_o=16'hFFFF.
- Flush: both buffers and the output register full, assert flush_i one cycle -> next cycle wb_valid_o=0, both readys=1, no writeback of the flushed tags.
- Reset mid-stream: assert reset asynchronously between edges while wb_valid_o=1 -> wb_valid_o=0 immediately; after release, the next conflict grants lane 0.
